// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// instruction field layout and the watchdog result pattern.
package ctrl_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned GAP_W   = 4;

    localparam int unsigned RX_MSB   = 15;
    localparam int unsigned RX_LSB   = 13;
    localparam int unsigned RY_MSB   = 12;
    localparam int unsigned RY_LSB   = 10;
    localparam int unsigned SEL_MSB  = 6;
    localparam int unsigned SEL_LSB  = 3;
    localparam int unsigned MODE_BIT = 2;

    localparam logic [INSTR_W-1:0] TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_CALC,
        S_WAIT,
        S_RESP
    } seq_state_t;

    // Instruction word as seen by the control unit.
    typedef struct packed {
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] rsvd_hi;
        logic [3:0] sel;
        logic       mode;
        logic [1:0] rsvd_lo;
    } instr_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Host push/result port and control-unit strobe port of the sequencer.
// master = sequencer side, slave = host / control-unit side.
interface instr_sequencer_if
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) ();

    logic                 push_valid;
    instr_t               push_data;
    logic                 push_ready;
    instr_t               instruction;
    logic                 en_i;
    logic                 en_s;
    logic                 en_c;
    logic                 done;
    logic [INSTR_W-1:0]   d_out;
    logic                 res_valid;
    logic [INSTR_W-1:0]   res_data;
    logic                 res_ready;
    logic                 busy;
    logic [CNT_W-1:0]     done_count;
    logic                 timeout_err;

    modport master (
        input  push_valid, push_data, done, d_out, res_ready,
        output push_ready, instruction, en_i, en_s, en_c,
               res_valid, res_data, busy, done_count, timeout_err
    );

    modport slave (
        output push_valid, push_data, done, d_out, res_ready,
        input  push_ready, instruction, en_i, en_s, en_c,
               res_valid, res_data, busy, done_count, timeout_err
    );

endinterface

// File: rtl/seq_fifo.sv
// Synchronous FIFO holding pending instructions; full/empty are registered
// so push_ready never depends combinationally on a same-cycle pop.
module seq_fifo
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = INSTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/instr_sequencer.sv
// Issues buffered instructions to the control unit via en_i/en_s/en_c and
// returns d_out to the host. Optional WAIT watchdog: define SEQ_TIMEOUT_EN.
module instr_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned STEP_GAP = 0,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic              clk,
    input  logic              reset,
    instr_sequencer_if.master bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STEP_GAP > 15 ||
        TIMEOUT == 0 || CNT_W == 0) begin : g_bad_param
        $error("instr_sequencer: illegal parameter set");
    end

    seq_state_t          state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    instr_t              instr_q, instr_d;
    logic                en_i_q, en_i_d;
    logic                en_s_q, en_s_d;
    logic                en_c_q, en_c_d;
    logic                res_valid_q, res_valid_d;
    logic [INSTR_W-1:0]  res_data_q, res_data_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pop;
    logic [INSTR_W-1:0]  fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                tmo_q, tmo_d;
`endif

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (bus.push_valid),
        .push_data_i (bus.push_data),
        .pop_i       (pop),
        .rd_data_c   (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next-state logic; each strobe state lasts STEP_GAP+1 cycles with the
    // strobe on its final cycle, so every strobe is preceded by the gap.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        instr_d     = instr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wd_d        = wd_q;
        tmo_d       = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !res_valid_q) begin
                    pop     = 1'b1;
                    instr_d = fifo_head;
                    gap_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gap_q == GAP_W'(STEP_GAP)) begin
                    gap_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_LOAD: begin
                if (gap_q == GAP_W'(STEP_GAP)) begin
                    gap_d   = '0;
                    state_d = S_CALC;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_CALC: begin
                if (gap_q == GAP_W'(STEP_GAP)) begin
                    gap_d   = '0;
                    state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_WAIT: begin
                if (bus.done) begin
                    res_data_d  = bus.d_out;
                    res_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = S_RESP;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    tmo_d       = 1'b1;
                    res_data_d  = TIMEOUT_DATA;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_i_d = (state_d == S_ISSUE) && (gap_d == GAP_W'(STEP_GAP));
        en_s_d = (state_d == S_LOAD)  && (gap_d == GAP_W'(STEP_GAP));
        en_c_d = (state_d == S_CALC)  && (gap_d == GAP_W'(STEP_GAP));
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            instr_q     <= '0;
            en_i_q      <= 1'b0;
            en_s_q      <= 1'b0;
            en_c_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            instr_q     <= instr_d;
            en_i_q      <= en_i_d;
            en_s_q      <= en_s_d;
            en_c_q      <= en_c_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.timeout_err = tmo_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.push_ready  = !fifo_full;
    assign bus.instruction = instr_q;
    assign bus.en_i        = en_i_q;
    assign bus.en_s        = en_s_q;
    assign bus.en_c        = en_c_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.busy        = busy_q;
    assign bus.done_count  = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: cycle table for a single issue, directed corner
// sequences, and randomized traffic against a FIFO-order reference model.
module tb_instr_sequencer;
    import ctrl_seq_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_sequencer_if #(.CNT_W(CNT_W)) b0 ();
    instr_sequencer_if #(.CNT_W(CNT_W)) b3 ();

    instr_sequencer #(.DEPTH(4), .STEP_GAP(0), .CNT_W(CNT_W), .TIMEOUT(32))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    instr_sequencer #(.DEPTH(4), .STEP_GAP(3), .CNT_W(CNT_W), .TIMEOUT(32))
        dut3 (.clk(clk), .reset(reset), .bus(b3));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control-unit result function used by the responders and the model.
    function automatic logic [15:0] cu_result(input logic [15:0] x);
        return x ^ 16'h81BD;
    endfunction

    // Control-unit responders: capture on en_i, done two cycles after en_c.
    logic mute, stray;
    logic d1_0, d1_3;
    logic [15:0] cap0, cap3;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_0 <= 1'b0; b0.done <= 1'b0; b0.d_out <= '0; cap0 <= '0;
        end else begin
            d1_0    <= b0.en_c && !mute;
            b0.done <= d1_0 || stray;
            if (b0.en_i) cap0 <= b0.instruction;
            if (d1_0) b0.d_out <= cu_result(cap0);
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_3 <= 1'b0; b3.done <= 1'b0; b3.d_out <= '0; cap3 <= '0;
        end else begin
            d1_3    <= b3.en_c;
            b3.done <= d1_3;
            if (b3.en_i) cap3 <= b3.instruction;
            if (d1_3) b3.d_out <= cu_result(cap3);
        end
    end

    // Reference model: accepted pushes in order; results in the same order.
    logic [15:0] issue_q[$];
    logic [15:0] res_q[$];
    logic [15:0] cur0;
    logic [7:0]  completed;

    always @(negedge clk) begin
        if (!reset) begin
            if (b0.push_valid && b0.push_ready) begin
                issue_q.push_back(b0.push_data);
                res_q.push_back(cu_result(b0.push_data));
            end
            if (b0.en_i || b0.en_s || b0.en_c)
                check("strobe_onehot", 32'(b0.en_i) + 32'(b0.en_s) + 32'(b0.en_c), 32'd1);
            if (b0.en_i) begin
                check("issue_has_pending", 32'(issue_q.size() != 0), 32'd1);
                if (issue_q.size() != 0) begin
                    cur0 = issue_q.pop_front();
                    check("instr_at_en_i", 32'(b0.instruction), 32'(cur0));
                end
            end
            if (b0.en_s || b0.en_c || b0.res_valid)
                check("instr_held", 32'(b0.instruction), 32'(cur0));
            if (b0.res_valid && b0.res_ready) begin
                check("result_pending", 32'(res_q.size() != 0), 32'd1);
                if (res_q.size() != 0) begin
                    check("res_data", 32'(b0.res_data), 32'(res_q.pop_front()));
                    completed = completed + 8'd1;
                    check("done_count", 32'(b0.done_count), 32'(completed));
                end
            end
        end
    end

    typedef struct {
        logic        pv;
        logic [15:0] pd;
        logic        rr;
        logic        ei, es, ec, rv, bsy, pr;
        logic [15:0] instr, rd;
        logic [7:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic pv, input logic [15:0] pd, input logic rr,
                                input logic ei, input logic es, input logic ec,
                                input logic rv, input logic bsy, input logic pr,
                                input logic [15:0] instr, input logic [15:0] rd,
                                input logic [7:0] cnt);
        vec_t v;
        v.pv = pv; v.pd = pd; v.rr = rr; v.ei = ei; v.es = es; v.ec = ec;
        v.rv = rv; v.bsy = bsy; v.pr = pr; v.instr = instr; v.rd = rd; v.cnt = cnt;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        issue_q.delete();
        res_q.delete();
        completed = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((res_q.size() != 0 || b0.busy) && n < budget) begin
            b0.res_ready = (n % 2 == 1);
            tick();
            n++;
        end
        b0.res_ready = 1'b0;
        check("drain_results_left", 32'(res_q.size()), 32'd0);
        check("drain_idle", 32'(b0.busy), 32'd0);
    endtask

    task automatic wait_en_c(input string name);
        int w = 0;
        while (!b0.en_c && w < 40) begin
            tick();
            w++;
        end
        check(name, 32'(b0.en_c), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

    initial begin
        vec_t tbl [9];
        int acc, guard, w;
        int ti, ts, tc, tv;
        logic [15:0] rd3, exp4;

        reset = 1'b1;
        mute = 1'b0; stray = 1'b0; completed = '0; cur0 = '0;
        b0.push_valid = 1'b0; b0.push_data = '0; b0.res_ready = 1'b0;
        b3.push_valid = 1'b0; b3.push_data = '0; b3.res_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_en_i", 32'(b0.en_i), 0);
        check("rst_en_s", 32'(b0.en_s), 0);
        check("rst_en_c", 32'(b0.en_c), 0);
        check("rst_res_valid", 32'(b0.res_valid), 0);
        check("rst_res_data", 32'(b0.res_data), 0);
        check("rst_busy", 32'(b0.busy), 0);
        check("rst_done_count", 32'(b0.done_count), 0);
        check("rst_timeout_err", 32'(b0.timeout_err), 0);
        check("rst_instruction", 32'(b0.instruction), 0);
        check("rst_push_ready", 32'(b0.push_ready), 1);
        reset = 1'b0;

        // Single instruction, cycle by cycle
        tbl[0] = mk(1, 16'h2418, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0);
        tbl[1] = mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0);
        tbl[2] = mk(0, 16'h0000, 1, 1, 0, 0, 0, 1, 1, 16'h2418, 16'h0000, 0);
        tbl[3] = mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 1, 16'h2418, 16'h0000, 0);
        tbl[4] = mk(0, 16'h0000, 1, 0, 0, 1, 0, 1, 1, 16'h2418, 16'h0000, 0);
        tbl[5] = mk(0, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 16'h2418, 16'h0000, 0);
        tbl[6] = mk(0, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 16'h2418, 16'h0000, 0);
        tbl[7] = mk(0, 16'h0000, 1, 0, 0, 0, 1, 1, 1, 16'h2418, 16'hA5A5, 1);
        tbl[8] = mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 16'h2418, 16'hA5A5, 1);
        for (int r = 0; r < 9; r++) begin
            check($sformatf("t1_en_i[%0d]", r), 32'(b0.en_i), 32'(tbl[r].ei));
            check($sformatf("t1_en_s[%0d]", r), 32'(b0.en_s), 32'(tbl[r].es));
            check($sformatf("t1_en_c[%0d]", r), 32'(b0.en_c), 32'(tbl[r].ec));
            check($sformatf("t1_res_valid[%0d]", r), 32'(b0.res_valid), 32'(tbl[r].rv));
            check($sformatf("t1_busy[%0d]", r), 32'(b0.busy), 32'(tbl[r].bsy));
            check($sformatf("t1_push_ready[%0d]", r), 32'(b0.push_ready), 32'(tbl[r].pr));
            check($sformatf("t1_instr[%0d]", r), 32'(b0.instruction), 32'(tbl[r].instr));
            check($sformatf("t1_res_data[%0d]", r), 32'(b0.res_data), 32'(tbl[r].rd));
            check($sformatf("t1_count[%0d]", r), 32'(b0.done_count), 32'(tbl[r].cnt));
            b0.push_valid = tbl[r].pv;
            b0.push_data  = instr_t'(tbl[r].pd);
            b0.res_ready  = tbl[r].rr;
            tick();
        end
        b0.push_valid = 1'b0;
        b0.res_ready  = 1'b0;

        // FIFO fill with no result progress
        acc = 0; guard = 0;
        while (b0.push_ready && guard < 20) begin
            b0.push_valid = 1'b1;
            b0.push_data  = instr_t'(16'h3000 + 16'(acc) * 16'h0111);
            tick();
            acc++;
            guard++;
        end
        check("t2_accepted", 32'(acc), 32'd5);
        check("t2_push_ready_full", 32'(b0.push_ready), 32'd0);
        b0.push_data = instr_t'(16'hFFFF);
        tick();
        check("t2_still_full", 32'(b0.push_ready), 32'd0);
        b0.push_valid = 1'b0;
        drain(200);

        // Result held by host: no new issue until handshake
        b0.push_valid = 1'b1; b0.push_data = instr_t'(16'h4C2A); tick();
        b0.push_data = instr_t'(16'h5E3C); tick();
        b0.push_valid = 1'b0;
        w = 0;
        while (!b0.res_valid && w < 30) begin tick(); w++; end
        check("t4_res_valid_seen", 32'(b0.res_valid), 32'd1);
        exp4 = cu_result(16'h4C2A);
        for (int c = 0; c < 10; c++) begin
            check("t4_no_issue", 32'(b0.en_i), 32'd0);
            check("t4_res_data_stable", 32'(b0.res_data), 32'(exp4));
            tick();
        end
        b0.res_ready = 1'b1; tick(); b0.res_ready = 1'b0;
        check("t4_after_hs_en_i", 32'(b0.en_i), 32'd0);
        check("t4_after_hs_res_valid", 32'(b0.res_valid), 32'd0);
        tick();
        check("t4_resume_en_i", 32'(b0.en_i), 32'd1);
        check("t4_resume_instr", 32'(b0.instruction), 32'h5E3C);
        drain(100);

        // done outside WAIT is ignored
        stray = 1'b1; tick(); stray = 1'b0;
        tick(); tick();
        check("stray_res_valid", 32'(b0.res_valid), 32'd0);
        check("stray_busy", 32'(b0.busy), 32'd0);
        check("stray_count", 32'(b0.done_count), 32'(completed));

        // STEP_GAP=3 strobe spacing
        b3.res_ready = 1'b1;
        b3.push_valid = 1'b1; b3.push_data = instr_t'(16'h6B54); tick();
        b3.push_valid = 1'b0;
        ti = -1; ts = -1; tc = -1; tv = -1; rd3 = '0;
        for (int c = 0; c < 60; c++) begin
            check("t3_onehot", 32'((32'(b3.en_i) + 32'(b3.en_s) + 32'(b3.en_c)) <= 1), 32'd1);
            if (b3.en_i) ti = c;
            if (b3.en_s) ts = c;
            if (b3.en_c) tc = c;
            if (b3.res_valid && tv < 0) begin tv = c; rd3 = b3.res_data; end
            tick();
        end
        check("t3_first_en_i", 32'(ti), 32'd4);
        check("t3_gap_i_s", 32'(ts - ti), 32'd4);
        check("t3_gap_s_c", 32'(tc - ts), 32'd4);
        check("t3_c_to_valid", 32'(tv - tc), 32'd3);
        check("t3_res_data", 32'(rd3), 32'(cu_result(16'h6B54)));
        check("t3_done_count", 32'(b3.done_count), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            b0.push_valid = ($urandom_range(0, 3) == 0);
            b0.push_data  = instr_t'(16'($urandom));
            b0.res_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        b0.push_valid = 1'b0;
        drain(400);

        // Reset in the middle of CALC, with instructions still queued
        b0.res_ready = 1'b1;
        b0.push_valid = 1'b1; b0.push_data = instr_t'(16'h1111); tick();
        b0.push_data = instr_t'(16'h2222); tick();
        b0.push_data = instr_t'(16'h3333); tick();
        b0.push_valid = 1'b0;
        wait_en_c("t5_reached_calc");
        #3;
        reset = 1'b1;
        issue_q.delete(); res_q.delete(); completed = '0;
        #1;
        check("t5_en_i", 32'(b0.en_i), 0);
        check("t5_en_s", 32'(b0.en_s), 0);
        check("t5_en_c", 32'(b0.en_c), 0);
        check("t5_res_valid", 32'(b0.res_valid), 0);
        check("t5_busy", 32'(b0.busy), 0);
        check("t5_push_ready", 32'(b0.push_ready), 1);
        check("t5_done_count", 32'(b0.done_count), 0);
        tick();
        reset = 1'b0;
        b0.res_ready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            check("t5_stays_idle", 32'(b0.busy), 32'd0);
            tick();
        end

        // Control unit never answers
        mute = 1'b1;
        b0.push_valid = 1'b1; b0.push_data = instr_t'(16'h7A11); tick();
        b0.push_valid = 1'b0;
        wait_en_c("t6_reached_calc");
        repeat (32) tick();
`ifdef SEQ_TIMEOUT_EN
        check("t6_no_err_early", 32'(b0.timeout_err), 32'd0);
        check("t6_no_res_early", 32'(b0.res_valid), 32'd0);
        tick();
        check("t6_timeout_err", 32'(b0.timeout_err), 32'd1);
        check("t6_res_valid", 32'(b0.res_valid), 32'd1);
        check("t6_res_data", 32'(b0.res_data), 32'(TIMEOUT_DATA));
`else
        repeat (20) tick();
        check("t6_timeout_err", 32'(b0.timeout_err), 32'd0);
        check("t6_still_waiting", 32'(b0.res_valid), 32'd0);
`endif
        check("t6_busy", 32'(b0.busy), 32'd1);
        check("t6_done_count", 32'(b0.done_count), 32'(completed));
        do_reset();
        mute = 1'b0;
        check("t6_err_cleared", 32'(b0.timeout_err), 32'd0);
        check("t6_idle_after_reset", 32'(b0.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
